// File: rtl/lut6_cfg_pkg.sv
// Shared types and constants for the LUT6 configuration writer.
package lut6_cfg_pkg;

  localparam int LUT_BITS = 64;
  localparam int ADDR_W   = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // A single table still needs a one-bit select port.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/lut6_cfg_shift.sv
// Shadow shift register and bit counter for one serial table frame.
// The shadow is only copied into a table on commit, so partial frames never
// reach the read port.
module lut6_cfg_shift
  import lut6_cfg_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                shift_en,
  input  logic                clear,
  input  logic                sdi,
  output logic [LUT_BITS-1:0] shadow,
  output logic                last
);

  logic [ADDR_W-1:0] cnt;

  // Shift MSB-first data in and count accepted bits; clear restarts the count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow <= '0;
      cnt    <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (shift_en) begin
      shadow <= {shadow[LUT_BITS-2:0], sdi};
      cnt    <= cnt + ADDR_W'(1);
    end
  end

  assign last = shift_en && (cnt == ADDR_W'(LUT_BITS - 1));

endmodule

// File: rtl/lut6_cfg_writer.sv
// Configuration writer for NUM_LUTS 64-bit LUT6 truth tables: serial frame
// load with atomic commit, direct single-bit writes, and a combinational
// LUT6-style read port.
//
//   state  | meaning
//   IDLE   | waiting for START; serial input not accepted
//   SHIFT  | accepting 64 bits into the shadow register; ABORT drops the frame
//   COMMIT | one cycle; shadow copied into the selected table at the exit edge
module lut6_cfg_writer
  import lut6_cfg_pkg::*;
#(
  parameter int                  NUM_LUTS = 4,
  parameter int                  SELW     = sel_width(NUM_LUTS),
  parameter logic [LUT_BITS-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [SELW-1:0]   sel,
  input  logic              sdi,
  input  logic              svalid,
  output logic              sready,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              we,
  input  logic [SELW-1:0]   wsel,
  input  logic [ADDR_W-1:0] wad,
  input  logic              wd,
  input  logic [SELW-1:0]   rsel,
  input  logic [ADDR_W-1:0] rad,
  output logic              z
);

  state_t              state_q, state_d;
  logic [SELW-1:0]     sel_q;
  logic                sel_ok;
  logic                clear, commit, err_d;
  logic                shift_en, last;
  logic [LUT_BITS-1:0] shadow;
  logic [LUT_BITS-1:0] tbl [NUM_LUTS];

  assign sel_ok   = int'(sel) < NUM_LUTS;
  assign sready   = (state_q == SHIFT);
  assign busy     = (state_q != IDLE);
  // ABORT takes priority over a handshake in the same cycle.
  assign shift_en = (state_q == SHIFT) && svalid && !abort;

  lut6_cfg_shift u_shift (
    .clk      (clk),
    .rstn     (rstn),
    .shift_en (shift_en),
    .clear    (clear),
    .sdi      (sdi),
    .shadow   (shadow),
    .last     (last)
  );

  // State, captured table select and the one-cycle status pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      sel_q   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= commit;
      err     <= err_d;
      if (clear) sel_q <= sel;
    end
  end

  // Next-state and frame control decode.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    commit  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (sel_ok) begin
            state_d = SHIFT;
            clear   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (abort)     state_d = IDLE;
        else if (last) state_d = COMMIT;
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Table array: a commit to a table overrides a direct write to the same table.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_LUTS; i++) tbl[i] <= INIT_VAL;
    end else begin
      for (int i = 0; i < NUM_LUTS; i++) begin
        if (commit && (sel_q == SELW'(i)))   tbl[i]      <= shadow;
        else if (we && (wsel == SELW'(i)))   tbl[i][wad] <= wd;
      end
    end
  end

  // Read mux; selects with no backing table read as 0.
  always_comb begin
    z = 1'b0;
    for (int i = 0; i < NUM_LUTS; i++) begin
      if (rsel == SELW'(i)) z = tbl[i][rad];
    end
  end

endmodule

// File: tb/tb_lut6_cfg_writer.sv
`timescale 1ns/1ps
module tb_lut6_cfg_writer;

  localparam logic [63:0] INIT4 = 64'hC3C3_5A5A_0F0F_9669;
  localparam logic [63:0] INIT3 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rstn;
  logic start, sdi, svalid, abort, we, wd;
  logic [1:0] sel, wsel, rsel;
  logic [5:0] wad, rad;
  logic sready, busy, done, err, z;

  logic start3, we3;
  logic [1:0] sel3, wsel3, rsel3;
  logic sready3, busy3, done3, err3, z3;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_tbl [4];

  always #5 clk = ~clk;

  lut6_cfg_writer #(.NUM_LUTS(4), .SELW(2), .INIT_VAL(INIT4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .sel(sel), .sdi(sdi), .svalid(svalid),
    .sready(sready), .abort(abort), .busy(busy), .done(done), .err(err),
    .we(we), .wsel(wsel), .wad(wad), .wd(wd), .rsel(rsel), .rad(rad), .z(z)
  );

  lut6_cfg_writer #(.NUM_LUTS(3), .SELW(2), .INIT_VAL(INIT3)) dut3 (
    .clk(clk), .rstn(rstn), .start(start3), .sel(sel3), .sdi(1'b0), .svalid(1'b0),
    .sready(sready3), .abort(1'b0), .busy(busy3), .done(done3), .err(err3),
    .we(we3), .wsel(wsel3), .wad(wad), .wd(wd), .rsel(rsel3), .rad(rad), .z(z3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_table(input logic [1:0] t, output logic [63:0] v);
    rsel = t;
    for (int i = 0; i < 64; i++) begin
      rad = 6'(i);
      #1;
      v[i] = z;
    end
  endtask

  task automatic read_table3(input logic [1:0] t, output logic [63:0] v);
    rsel3 = t;
    for (int i = 0; i < 64; i++) begin
      rad = 6'(i);
      #1;
      v[i] = z3;
    end
  endtask

  task automatic check_tables(input string tag);
    logic [63:0] v;
    for (int t = 0; t < 4; t++) begin
      read_table(2'(t), v);
      n_checks++;
      if (v !== exp_tbl[t]) begin
        n_fail++;
        $display("FAIL %s tbl%0d: got %h expected %h", tag, t, v, exp_tbl[t]);
      end
    end
  endtask

  task automatic do_start(input logic [1:0] s);
    start = 1'b1;
    sel   = s;
    tick();
    start = 1'b0;
  endtask

  // Streams bits first..first+count-1 of data, MSB first; each bit is consumed at the tick.
  task automatic stream(input logic [63:0] data, input int first, input int count, input bit gaps);
    for (int i = first; i < first + count; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        svalid = 1'b0;
        repeat (g) tick();
      end
      svalid = 1'b1;
      sdi    = data[63-i];
      tick();
    end
    svalid = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (busy !== 1'b0 || sready !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b sready=%b done=%b err=%b expected all 0", busy, sready, done, err);
    end
    check_tables("reset_init");
    rsel = 2'd0; rad = 6'h3F; #1;
    n_checks++;
    if (z !== exp_tbl[0][63]) begin
      n_fail++;
      $display("FAIL reset_z3f: got %b expected %b", z, exp_tbl[0][63]);
    end
    do_start(2'd1);
    stream(64'hFFFF_FFFF_FFFF_FFFF, 0, 30, 1'b0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midframe_busy: got %b expected 1", busy);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || sready !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: busy=%b sready=%b done=%b expected 0", busy, sready, done);
    end
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_done: done=%b busy=%b expected 0", done, busy);
    end
    check_tables("reset_dropped_frame");
  endtask

  task automatic test_load();
    logic [63:0] d;
    d = 64'hDEAD_BEEF_0123_4567;
    do_start(2'd1);
    n_checks++;
    if (busy !== 1'b1 || sready !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL load_shift_state: busy=%b sready=%b err=%b expected 1 1 0", busy, sready, err);
    end
    stream(d, 0, 64, 1'b1);
    // One edge after the last bit is consumed: in COMMIT, nothing written yet.
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1 || sready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_commit_state: done=%b busy=%b sready=%b expected 0 1 0", done, busy, sready);
    end
    rsel = 2'd1; rad = 6'd0; #1;
    n_checks++;
    if (z !== exp_tbl[1][0]) begin
      n_fail++;
      $display("FAIL load_no_early_write: got %b expected %b", z, exp_tbl[1][0]);
    end
    tick();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL load_done_pulse: done=%b busy=%b expected 1 0", done, busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL load_done_width: got %b expected 0", done);
    end
    exp_tbl[1] = d;
    check_tables("load");
  endtask

  task automatic test_abort();
    logic [63:0] a, x;
    a = 64'h0123_4567_89AB_CDEF;
    x = 64'h0F0F_F0F0_1234_5600;
    do_start(2'd0);
    stream(a, 0, 40, 1'b1);
    abort = 1'b1; svalid = 1'b1; sdi = 1'b1;
    tick();
    abort = 1'b0; svalid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || sready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_to_idle: busy=%b sready=%b expected 0 0", busy, sready);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %b expected 0", done);
    end
    check_tables("abort_unchanged");
    do_start(2'd0);
    stream(a, 0, 64, 1'b0);
    tick();
    exp_tbl[0] = a;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_reload_done: got %b expected 1", done);
    end
    do_start(2'd3);
    stream(x, 0, 64, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_tbl[3] = x;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_in_commit_done: got %b expected 1", done);
    end
    check_tables("abort_after");
  endtask

  task automatic test_collision();
    logic [63:0] d2, d2b;
    d2  = 64'hFFFF_FFFF_FFFF_FFDF;
    d2b = 64'h5555_AAAA_3333_CCC0;
    do_start(2'd2);
    stream(d2, 0, 64, 1'b0);
    we = 1'b1; wsel = 2'd2; wad = 6'd5; wd = 1'b1;
    tick();
    we = 1'b0;
    exp_tbl[2] = d2;
    rsel = 2'd2; rad = 6'd5; #1;
    n_checks++;
    if (z !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_same_tbl bit5: got %b expected 0", z);
    end
    do_start(2'd2);
    stream(d2b, 0, 64, 1'b0);
    we = 1'b1; wsel = 2'd3; wad = 6'd5; wd = 1'b1;
    tick();
    we = 1'b0;
    exp_tbl[2] = d2b;
    exp_tbl[3] = 64'h0F0F_F0F0_1234_5620;
    check_tables("collision_other_tbl");
    we = 1'b1; wsel = 2'd0; wad = 6'd10; wd = 1'b0;
    tick();
    we = 1'b0;
    exp_tbl[0] = 64'h0123_4567_89AB_C9EF;
    check_tables("direct_write");
  endtask

  task automatic test_range();
    logic [63:0] v;
    start3 = 1'b1; sel3 = 2'd3;
    tick();
    start3 = 1'b0;
    n_checks++;
    if (err3 !== 1'b1 || busy3 !== 1'b0) begin
      n_fail++;
      $display("FAIL range_err: err=%b busy=%b expected 1 0", err3, busy3);
    end
    tick();
    n_checks++;
    if (err3 !== 1'b0 || busy3 !== 1'b0) begin
      n_fail++;
      $display("FAIL range_err_width: err=%b busy=%b expected 0 0", err3, busy3);
    end
    we3 = 1'b1; wsel3 = 2'd3; wad = 6'd5; wd = 1'b0;
    tick();
    we3 = 1'b0;
    for (int t = 0; t < 3; t++) begin
      read_table3(2'(t), v);
      n_checks++;
      if (v !== INIT3) begin
        n_fail++;
        $display("FAIL range_tbl%0d: got %h expected %h", t, v, INIT3);
      end
    end
    rsel3 = 2'd3; rad = 6'h3F; #1;
    n_checks++;
    if (z3 !== 1'b0) begin
      n_fail++;
      $display("FAIL range_rsel3_z: got %b expected 0", z3);
    end
  endtask

  task automatic test_protocol();
    logic [63:0] p;
    p = 64'h0F1E_2D3C_4B5A_6978;
    svalid = 1'b1; sdi = 1'b1;
    tick();
    n_checks++;
    if (sready !== 1'b0) begin
      n_fail++;
      $display("FAIL proto_idle_sready: got %b expected 0", sready);
    end
    svalid = 1'b0;
    do_start(2'd0);
    stream(p, 0, 20, 1'b0);
    start = 1'b1; sel = 2'd1;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || sready !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL proto_start_busy: busy=%b sready=%b err=%b expected 1 1 0", busy, sready, err);
    end
    stream(p, 20, 43, 1'b1);
    n_checks++;
    if (sready !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_63_bits: sready=%b expected 1", sready);
    end
    stream(p, 63, 1, 1'b0);
    n_checks++;
    if (sready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_commit_state: sready=%b busy=%b expected 0 1", sready, busy);
    end
    svalid = 1'b1; sdi = 1'b1;
    tick();
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_done: got %b expected 1", done);
    end
    tick();
    svalid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || sready !== 1'b0) begin
      n_fail++;
      $display("FAIL proto_back_idle: busy=%b sready=%b expected 0 0", busy, sready);
    end
    exp_tbl[0] = p;
    check_tables("protocol");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    start = 1'b0; sel = '0; sdi = 1'b0; svalid = 1'b0; abort = 1'b0;
    we = 1'b0; wsel = '0; wad = '0; wd = 1'b0; rsel = '0; rad = '0;
    start3 = 1'b0; sel3 = '0; we3 = 1'b0; wsel3 = '0; rsel3 = '0;
    for (int t = 0; t < 4; t++) exp_tbl[t] = INIT4;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    test_reset();
    test_load();
    test_abort();
    test_collision();
    test_range();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
